// File: rtl/pc_unit.sv
// Program-counter unit: LOAD/RUN/HALT control, prioritised redirects and a
// circular return-address stack with sticky overflow/underflow reporting.
module pc_unit #(
    parameter int unsigned           PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int unsigned           STEP         = 4,
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                write_en,
    input  logic                stall,
    input  logic                halt,
    input  logic                resume,
    input  logic                exc_valid,
    input  logic [PC_WIDTH-1:0] exc_target,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                ras_push,
    input  logic [PC_WIDTH-1:0] link_addr,
    input  logic                ras_pop,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus_step,
    output logic [1:0]          state,
    output logic                ras_empty,
    output logic                ras_err,
    output logic                misaligned
);

    localparam int unsigned         PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned         CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'(STEP - 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]    tos_q, tos_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                empty_q, empty_d;
    logic                mis_q, mis_d;

    logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic                ras_we;
    logic [PTR_W-1:0]    ras_waddr;

    logic                redir;
    logic [PC_WIDTH-1:0] redir_tgt;
    logic [PC_WIDTH-1:0] ras_top;
    logic [PTR_W-1:0]    tos_inc, tos_dec;
    logic                ras_has;
    logic                ras_full;

    assign pc_plus_step = pc_q + PC_WIDTH'(STEP);
    assign ras_top      = ras_mem_q[tos_q];
    assign tos_inc      = tos_q + PTR_W'(1);
    assign tos_dec      = tos_q - PTR_W'(1);
    assign ras_has      = (cnt_q != '0);
    assign ras_full     = (cnt_q == CNT_FULL);

    // Next-state: load override, then per-state behaviour; RUN applies the redirect priority chain.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tos_d     = tos_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mis_d     = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = tos_q;
        redir     = 1'b0;
        redir_tgt = pc_q;

        if (write_en) begin
            state_d = ST_LOAD;
            pc_d    = RESET_VECTOR;
            tos_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: state_d = ST_RUN;
                ST_HALT: begin
                    if (resume) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (exc_valid) begin
                        redir     = 1'b1;
                        redir_tgt = exc_target;
                    end else if (!stall) begin
                        if (halt) begin
                            state_d = ST_HALT;
                        end else begin
                            // Stack update; a push+pop on a live stack replaces the top in place.
                            if (ras_push && ras_pop && ras_has) begin
                                ras_we    = 1'b1;
                                ras_waddr = tos_q;
                            end else if (ras_push) begin
                                ras_we    = 1'b1;
                                ras_waddr = tos_inc;
                                tos_d     = tos_inc;
                                if (ras_full) begin
                                    err_d = 1'b1;
                                end else begin
                                    cnt_d = cnt_q + CNT_W'(1);
                                end
                                if (ras_pop) begin
                                    err_d = 1'b1;
                                end
                            end else if (ras_pop) begin
                                if (ras_has) begin
                                    tos_d = tos_dec;
                                    cnt_d = cnt_q - CNT_W'(1);
                                end else begin
                                    err_d = 1'b1;
                                end
                            end

                            if (branch_valid) begin
                                redir     = 1'b1;
                                redir_tgt = branch_target;
                            end else if (ras_pop && ras_has) begin
                                redir     = 1'b1;
                                redir_tgt = ras_top;
                            end else if (jump_valid) begin
                                redir     = 1'b1;
                                redir_tgt = jump_target;
                            end else begin
                                pc_d = pc_plus_step;
                            end
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (redir) begin
            pc_d  = redir_tgt & ~LOW_MASK;
            mis_d = |(redir_tgt & LOW_MASK);
        end
    end

    assign empty_d = (cnt_d == '0);

    // Architectural state and stack storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            tos_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            mis_q   <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tos_q   <= tos_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            empty_q <= empty_d;
            mis_q   <= mis_d;
            if (ras_we) begin
                ras_mem_q[ras_waddr] <= link_addr;
            end
        end
    end

    assign pc         = pc_q;
    assign state      = state_q;
    assign ras_empty  = empty_q;
    assign ras_err    = err_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        write_en = 1'b0, stall = 1'b0, halt = 1'b0, resume = 1'b0;
    logic        exc_valid = 1'b0, branch_valid = 1'b0, jump_valid = 1'b0;
    logic        ras_push = 1'b0, ras_pop = 1'b0;
    logic [31:0] exc_target = '0, branch_target = '0, jump_target = '0, link_addr = '0;
    logic [31:0] pc, pc_plus_step;
    logic [1:0]  state;
    logic        ras_empty, ras_err, misaligned;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state: the stack is a queue, newest entry at the back.
    logic [31:0] m_pc = RV;
    logic [1:0]  m_state = 2'b01;
    logic [31:0] m_stk[$];
    bit          m_err = 1'b0;
    bit          m_mis = 1'b0;

    pc_unit #(
        .PC_WIDTH(32), .RESET_VECTOR(RV), .STEP(STEP), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .write_en(write_en), .stall(stall),
        .halt(halt), .resume(resume),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .ras_push(ras_push), .link_addr(link_addr), .ras_pop(ras_pop),
        .pc(pc), .pc_plus_step(pc_plus_step), .state(state),
        .ras_empty(ras_empty), .ras_err(ras_err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = RV;
        m_state = 2'b01;
        m_stk.delete();
        m_err   = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic m_step();
        bit          redir;
        bit          got;
        logic [31:0] t;
        logic [31:0] top;
        redir = 1'b0;
        got   = 1'b0;
        t     = '0;
        top   = '0;
        m_mis = 1'b0;
        if (write_en) begin
            m_state = 2'b00;
            m_pc    = RV;
            m_stk.delete();
            m_err   = 1'b0;
        end else if (m_state == 2'b00) begin
            m_state = 2'b01;
        end else if (m_state == 2'b10) begin
            if (resume) m_state = 2'b01;
        end else begin
            if (exc_valid) begin
                redir = 1'b1;
                t     = exc_target;
            end else if (!stall) begin
                if (halt) begin
                    m_state = 2'b10;
                end else begin
                    got = ras_pop && (m_stk.size() > 0);
                    if (got) top = m_stk[m_stk.size() - 1];
                    if (ras_push && got) begin
                        m_stk[m_stk.size() - 1] = link_addr;
                    end else if (ras_push) begin
                        if (m_stk.size() == DEPTH) begin
                            void'(m_stk.pop_front());
                            m_err = 1'b1;
                        end
                        m_stk.push_back(link_addr);
                        if (ras_pop) m_err = 1'b1;
                    end else if (ras_pop) begin
                        if (got) void'(m_stk.pop_back());
                        else m_err = 1'b1;
                    end
                    if (branch_valid) begin
                        redir = 1'b1; t = branch_target;
                    end else if (got) begin
                        redir = 1'b1; t = top;
                    end else if (jump_valid) begin
                        redir = 1'b1; t = jump_target;
                    end else begin
                        m_pc = m_pc + STEP;
                    end
                end
            end
            if (redir) begin
                m_pc  = t & ~(STEP - 1);
                m_mis = (t % STEP) != 0;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model pc", pc, m_pc);
            chk("model pc_plus_step", pc_plus_step, m_pc + STEP);
            chk("model state", 32'(state), 32'(m_state));
            chk("model ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
            chk("model ras_err", 32'(ras_err), 32'(m_err));
            chk("model misaligned", 32'(misaligned), 32'(m_mis));
        end
    end

    task automatic clear_inputs();
        write_en = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0;
        exc_valid = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    // One clock edge with the currently driven inputs, then return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic push(input logic [31:0] a);
        ras_push = 1'b1; link_addr = a;
        step();
    endtask

    task automatic pop();
        ras_pop = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] exp_pc;
        step();
        chk_en = 1'b1;
        step();
        chk("reset pc", pc, 32'h100);
        chk("reset state", 32'(state), 32'h1);
        chk("reset ras_empty", 32'(ras_empty), 32'h1);
        chk("reset ras_err", 32'(ras_err), 32'h0);
        chk("reset misaligned", 32'(misaligned), 32'h0);
        reset_n = 1'b1;

        exp_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq pc", pc, exp_pc);
            exp_pc = exp_pc + 32'h4;
        end

        stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h200;
        exc_valid = 1'b1; exc_target = 32'h80;
        step();
        chk("exc over stall", pc, 32'h80);
        stall = 1'b1; branch_valid = 1'b1;
        step();
        chk("stall over branch", pc, 32'h80);

        push(32'h10); push(32'h20); push(32'h30);
        chk("pc after pushes", pc, 32'h8C);
        pop(); chk("pop1", pc, 32'h30);
        pop(); chk("pop2", pc, 32'h20);
        pop(); chk("pop3", pc, 32'h10);
        chk("ras empty after pops", 32'(ras_empty), 32'h1);
        chk("no err after balanced", 32'(ras_err), 32'h0);

        for (int i = 0; i < 5; i++) push(32'h40 + 32'(i) * 32'h10);
        chk("overflow err", 32'(ras_err), 32'h1);
        pop(); chk("ovf pop1", pc, 32'h80);
        pop(); chk("ovf pop2", pc, 32'h70);
        pop(); chk("ovf pop3", pc, 32'h60);
        pop(); chk("ovf pop4", pc, 32'h50);
        pop(); chk("ovf pop5 seq", pc, 32'h54);
        chk("ovf empty", 32'(ras_empty), 32'h1);

        push(32'hA0);
        ras_push = 1'b1; ras_pop = 1'b1; link_addr = 32'hB0;
        step();
        chk("push+pop old top", pc, 32'hA0);
        chk("push+pop count kept", 32'(ras_empty), 32'h0);
        pop(); chk("push+pop new top", pc, 32'hB0);

        exc_valid = 1'b1; exc_target = 32'h123; halt = 1'b1;
        step();
        chk("exc over halt pc", pc, 32'h120);
        chk("exc over halt state", 32'(state), 32'h1);
        chk("exc misaligned", 32'(misaligned), 32'h1);

        for (int i = 0; i < 3; i++) begin
            write_en = 1'b1;
            step();
            chk("load state", 32'(state), 32'h0);
            chk("load pc", pc, 32'h100);
        end
        chk("load clears err", 32'(ras_err), 32'h0);
        step();
        chk("load->run state", 32'(state), 32'h1);
        chk("load->run pc", pc, 32'h100);
        step();
        chk("run after load", pc, 32'h104);
        halt = 1'b1;
        step();
        chk("halt state", 32'(state), 32'h2);
        for (int i = 0; i < 5; i++) begin
            branch_valid = 1'b1; branch_target = 32'h700; ras_push = 1'b1; link_addr = 32'h44;
            step();
            chk("halt hold pc", pc, 32'h104);
        end
        chk("halt ignores push", 32'(ras_empty), 32'h1);
        resume = 1'b1;
        step();
        chk("resume state", 32'(state), 32'h1);
        chk("resume pc", pc, 32'h104);
        step();
        chk("resume increments", pc, 32'h108);

        ras_pop = 1'b1; jump_valid = 1'b1; jump_target = 32'h300;
        step();
        chk("pop empty falls to jump", pc, 32'h300);
        chk("underflow err", 32'(ras_err), 32'h1);

        jump_valid = 1'b1; jump_target = 32'h1002;
        step();
        chk("misaligned jump pc", pc, 32'h1000);
        chk("misaligned pulse", 32'(misaligned), 32'h1);
        step();
        chk("misaligned clears", 32'(misaligned), 32'h0);
        chk("after misaligned", pc, 32'h1004);

        jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        chk("top pc", pc, 32'hFFFF_FFFC);
        chk("wrap pc_plus_step", pc_plus_step, 32'h0);
        step();
        chk("wrap pc", pc, 32'h0);

        halt = 1'b1;
        step();
        chk("halt before reset", 32'(state), 32'h2);
        reset_n = 1'b0;
        #2;
        chk("reset in halt pc", pc, 32'h100);
        chk("reset in halt state", 32'(state), 32'h1);
        chk("reset in halt err", 32'(ras_err), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("after mid reset", pc, 32'h104);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of the program counter and all address ports.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value after reset and after instruction-memory load.
REQ-003 SHALL have parameter STEP, default 4: sequential increment; a power of two, at least 1.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port write_en, input, 1: instruction-memory load in progress.
REQ-008 SHALL have port stall, input, 1: hold the PC.
REQ-009 SHALL have ports halt and resume, input, 1 each: enter and leave the HALT state.
REQ-010 SHALL have ports exc_valid and exc_target, input, 1 and PC_WIDTH: exception redirect.
REQ-011 SHALL have ports branch_valid and branch_target, input, 1 and PC_WIDTH: taken-branch redirect.
REQ-012 SHALL have ports jump_valid and jump_target, input, 1 and PC_WIDTH: jump redirect.
REQ-013 SHALL have ports ras_push and link_addr, input, 1 and PC_WIDTH: push a return address.
REQ-014 SHALL have port ras_pop, input, 1: return; redirect to the RAS top.
REQ-015 SHALL have ports pc and pc_plus_step, output, PC_WIDTH: current PC and pc+STEP.
REQ-016 SHALL have port state, output, 2: 00 LOAD, 01 RUN, 10 HALT.
REQ-017 SHALL have ports ras_empty, ras_err and misaligned, output, 1 each.

Function
REQ-018 SHALL compute pc_plus_step combinationally as pc+STEP modulo 2^PC_WIDTH, so the PC wraps at the top of the address space.
REQ-019 SHALL, in any state, enter LOAD on the next edge when write_en=1; pc=RESET_VECTOR and the RAS is emptied.
REQ-020 SHALL go LOAD->RUN on the first edge with write_en=0; pc stays RESET_VECTOR for that cycle.
REQ-021 SHALL go RUN->HALT when halt=1 and stall=0; in HALT pc is held and all redirects, stall and RAS operations are ignored.
REQ-022 SHALL go HALT->RUN when resume=1; pc is unchanged on that edge, and write_en overrides resume.
REQ-023 SHALL select next pc in RUN by strict priority:
- exc_target
- hold (stall)
- branch_target
- RAS top (ras_pop with RAS non-empty)
- jump_target
- pc_plus_step
REQ-024 SHALL let exc_valid override stall and halt on the same edge.
REQ-025 SHALL force the low log2(STEP) bits of any selected redirect target to zero and pulse misaligned=1 for exactly the following cycle.
REQ-026 SHALL gate RAS operations, performing them only in RUN with stall=0 and exc_valid=0.
REQ-027 SHALL implement the RAS as a circular buffer; push writes link_addr at the top.
REQ-028 SHALL, on push when full, overwrite the oldest entry, keep the count at RAS_DEPTH and set ras_err.
REQ-029 SHALL, on pop when empty, take no redirect (lower priorities apply), keep the count at 0 and set ras_err.
REQ-030 SHALL, on simultaneous push and pop, redirect to the old top, then replace it with link_addr, count unchanged; if the RAS is empty this is push only plus ras_err.
REQ-031 SHALL keep ras_err sticky until reset or LOAD entry; ras_empty=1 exactly when count=0.

Reset
REQ-032 SHALL, while reset_n=0, immediately force:
- pc=RESET_VECTOR
- state=RUN
- RAS count=0, ras_empty=1
- ras_err=0, misaligned=0
REQ-033 SHALL, when reset_n is asserted mid-operation (including during LOAD or HALT), discard all state.
REQ-034 SHALL not update on the first edge after reset_n rises unless the inputs request it.

Verification
REQ-035 SHALL verify sequential flow: reset release with RESET_VECTOR=0x100, no inputs, 3 edges -> pc 0x104, 0x108, 0x10C.
REQ-036 SHALL verify priority: stall=1 with branch_valid=1 (0x200) and exc_valid=1 (0x80) -> pc=0x80; stall plus branch only -> pc held.
REQ-037 SHALL verify RAS order: push 0x10, 0x20, 0x30, then pop three times -> pc 0x30, 0x20, 0x10, then ras_empty=1.
REQ-038 SHALL verify RAS overflow: RAS_DEPTH=4, push 5 times, then pop 5 times -> the first 4 pops return newest-first and the 5th is sequential; ras_err=1.
REQ-039 SHALL verify LOAD and HALT: write_en=1 for 3 cycles during RUN -> state=LOAD, pc=RESET_VECTOR; after release RUN; halt -> pc held 5 cycles; resume -> increments.
REQ-040 SHALL verify misalignment and wrap: jump_target=0x1002 with STEP=4 -> pc=0x1000 and misaligned pulses once; pc=0xFFFFFFFC sequential -> 0x00000000.
